mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Parametrised multicycle multiply/divide engine that replaces the separate Mult and Div blocks.
//  It computes signed or unsigned MULT/DIV on WIDTH-bit operands with a start/done handshake and
//  produces the HI/LO results consumed by the high/low registers. It flags divide-by-zero to CtrlUnit.
//  It sits beside ula32 in the datapath. Operands come from the A/B regs or memory via the div_src mux.
// PARAMETERS
//  WIDTH           32  operand width; HI and LO are each WIDTH bits; legal range 4..64
//  SIGNED_SUPPORT  1   1: op[0] selects signed/unsigned; 0: all ops unsigned, op[0] ignored
// PORTS
//  clock            in   1      rising-edge clock
//  reset            in   1      synchronous, active-high; clears all state
//  start            in   1      request; sampled only in IDLE
//  op               in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  a                in   WIDTH  multiplicand / dividend, sampled with start
//  b                in   WIDTH  multiplier / divisor, sampled with start
//  busy             out  1      high from the edge after start is accepted until done
//  done             out  1      one-cycle pulse; hi/lo are valid in the same cycle
//  hi               out  WIDTH  MULT: upper product; DIV: remainder
//  lo               out  WIDTH  MULT: lower product; DIV: quotient
//  div_0_exception  out  1      one-cycle pulse coincident with done when divisor == 0
// BEHAVIOUR
//  Reset
//   - state=IDLE; busy, done, hi, lo and div_0_exception are all 0.
//   - An operation in flight when reset is asserted is aborted; no done pulse is produced.
//  FSM IDLE -> CALC -> FIX -> DONE -> IDLE
//   - IDLE
//     - start=1 latches op, a, b.
//     - Operands are converted to magnitudes; the result signs are recorded.
//     - Step counter is loaded with WIDTH. Next state is CALC.
//     - DIV/DIVU with b==0 goes directly to DONE and sets a zero-divide flag.
//   - CALC: one radix-2 step per cycle; counter decrements; leaves for FIX when the counter reaches 1.
//     - Multiply: shift-add on a 2*WIDTH accumulator.
//     - Divide: restoring division; the remainder register is WIDTH+1 bits.
//   - FIX: applies the sign correction (two's-complement negate) to the result registers.
//   - DONE
//     - done=1 for exactly one cycle; hi/lo are updated on the edge entering DONE.
//     - hi/lo hold that value until the next DONE.
//     - Returns to IDLE.
//  Timing
//   - start accepted at edge k: busy=1 from edge k+1; done=1 in the cycle after edge k+WIDTH+2.
//   - For WIDTH=32 that is 34 cycles of latency.
//   - Divide-by-zero: done=1 and div_0_exception=1 after edge k+1. hi/lo are not written (keep old value).
//   - done and busy are never high in the same cycle; busy falls on the edge done rises.
//  Arithmetic
//   - MULT: {hi,lo} = full 2*WIDTH product.
//   - DIV signed: quotient truncates toward zero; remainder takes the dividend's sign.
//   - Signed MIN / -1: lo=MIN, hi=0 (wraps, no exception).
//   - Unsigned ops treat a and b as plain binary.
//  Handshake
//   - start while busy or in DONE is ignored and not queued.
//   - start in the cycle after done (IDLE) is accepted normally, so back-to-back ops are allowed.
//   - a, b and op may change freely after the accept edge.
// TESTING (WIDTH=32 unless noted)
//  - MULT a=FFFFFFFD(-3), b=7 -> hi=FFFFFFFF, lo=FFFFFFEB; done exactly 34 cycles after the start edge.
//  - MULTU a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001; repeat with SIGNED_SUPPORT=0 and op=00 -> same.
//  - DIV a=FFFFFFF9(-7), b=2 -> lo=FFFFFFFD, hi=FFFFFFFF; DIVU same operands -> lo=7FFFFFFC, hi=1.
//  - DIVU a=100, b=0 after a prior result -> done+div_0_exception 1 cycle after accept; hi/lo unchanged.
//  - DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0, div_0_exception=0.
//  - start pulsed at cycle 5 of busy -> ignored.
//  - reset at cycle 10 of busy -> no done, all outputs 0, next start completes correctly.
//  - Run the MULT and DIV cases at WIDTH=8: 7*-2 -> hi=FF, lo=F2; latency 10 cycles.

Source files
------------

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//   Multicycle radix-2 multiply/divide engine producing HI/LO results.
//   Signed operations work on magnitudes; the result sign is fixed up in a
//   dedicated FIX cycle before the result is published on hi/lo.
//
// Parameters
//   WIDTH           operand width (4..64); hi and lo are each WIDTH bits
//   SIGNED_SUPPORT  1: op[0]=0 selects signed; 0: every op is unsigned
//
// Ports
//   clock            rising-edge clock
//   reset            synchronous active-high reset, clears all state
//   start            request, sampled only while idle
//   op               00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b             multiplicand/dividend and multiplier/divisor
//   busy             high while the operation iterates (CALC/FIX)
//   done             one-cycle pulse, hi/lo valid in the same cycle
//   hi, lo           MULT: upper/lower product; DIV: remainder/quotient
//   div_0_exception  one-cycle pulse with done when the divisor is zero
// ---------------------------------------------------------------------------
module mult_div_unit #(
    parameter int WIDTH          = 32,
    parameter bit SIGNED_SUPPORT = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_0_exception
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Two's-complement negate when n is set.
    function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cneg_2w(input logic [2*WIDTH-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;     // MULT: {partial hi, multiplier}; DIV: low half is dividend/quotient
    logic [WIDTH:0]       rem_q, rem_d;     // partial remainder of the restoring divider
    logic [WIDTH-1:0]     opnd_q, opnd_d;   // multiplicand or divisor magnitude
    logic                 is_div_q, is_div_d;
    logic                 neg_lo_q, neg_lo_d;
    logic                 neg_hi_q, neg_hi_d;
    logic                 dz_q, dz_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 is_signed;
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       msum;
    logic [WIDTH+1:0]     ddiff;
    logic [2*WIDTH-1:0]   prod_fix;

    assign is_signed = SIGNED_SUPPORT & ~op[0];
    assign a_neg     = is_signed & a[WIDTH-1];
    assign b_neg     = is_signed & b[WIDTH-1];
    assign a_mag     = cneg_w(a, a_neg);
    assign b_mag     = cneg_w(b, b_neg);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        // Shift-add partial sum, carry kept in the top bit.
        msum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        // Trial subtract of the shifted remainder; MSB set means it went negative.
        ddiff    = {rem_q, acc_q[WIDTH-1]} - {2'b00, opnd_q};
        prod_fix = cneg_2w(acc_q, neg_lo_q);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    is_div_d = op[1];
                    neg_lo_d = a_neg ^ b_neg;
                    // Remainder follows the dividend's sign.
                    neg_hi_d = a_neg;
                    cnt_d    = CW'(WIDTH);
                    rem_d    = '0;
                    dz_d     = 1'b0;
                    if (op[1]) begin
                        acc_d  = {{WIDTH{1'b0}}, a_mag};
                        opnd_d = b_mag;
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, b_mag};
                        opnd_d = a_mag;
                    end
                    if (op[1] && (b == '0)) begin
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end

            // ---- iteration stage: one radix-2 step per cycle ----
            CALC: begin
                if (is_div_q) begin
                    if (!ddiff[WIDTH+1]) begin
                        rem_d              = ddiff[WIDTH:0];
                        acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d              = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
                        acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], 1'b0};
                    end
                end else if (acc_q[0]) begin
                    acc_d = {msum, acc_q[WIDTH-1:1]};
                end else begin
                    acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end

            // ---- sign fix-up stage: publishes the result on entry to DONE ----
            FIX: begin
                if (is_div_q) begin
                    lo_d = cneg_w(acc_q[WIDTH-1:0], neg_lo_q);
                    hi_d = cneg_w(rem_q[WIDTH-1:0], neg_hi_q);
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                state_d = DONE;
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy            = (state_q == CALC) || (state_q == FIX);
    assign done            = (state_q == DONE);
    assign div_0_exception = (state_q == DONE) && dz_q;
    assign hi              = hi_q;
    assign lo              = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
//   Directed and randomized checks of mult_div_unit. Three instances:
//   sel 0: WIDTH=32 signed-capable, sel 1: WIDTH=32 unsigned-only,
//   sel 2: WIDTH=8 signed-capable. Expected results go into a scoreboard
//   queue when an operation is started and are compared when done rises.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;

    logic clock;
    logic reset;

    logic        st0, st1, st2;
    logic [1:0]  op0, op1, op2;
    logic [31:0] a0, b0, a1, b1;
    logic [7:0]  a2, b2;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic [31:0] hi0, lo0, hi1, lo1;
    logic [7:0]  hi2, lo2;
    logic        dz0, dz1, dz2;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    int   vectors;
    int   miscompares;

    mult_div_unit #(.WIDTH(32), .SIGNED_SUPPORT(1'b1)) u_s32 (
        .clock(clock), .reset(reset), .start(st0), .op(op0), .a(a0), .b(b0),
        .busy(busy0), .done(done0), .hi(hi0), .lo(lo0), .div_0_exception(dz0)
    );

    mult_div_unit #(.WIDTH(32), .SIGNED_SUPPORT(1'b0)) u_u32 (
        .clock(clock), .reset(reset), .start(st1), .op(op1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .hi(hi1), .lo(lo1), .div_0_exception(dz1)
    );

    mult_div_unit #(.WIDTH(8), .SIGNED_SUPPORT(1'b1)) u_s8 (
        .clock(clock), .reset(reset), .start(st2), .op(op2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .hi(hi2), .lo(lo2), .div_0_exception(dz2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input int sel, input logic s, input logic [1:0] o,
                         input logic [31:0] av, input logic [31:0] bv);
        case (sel)
            0:       begin st0 = s; op0 = o; a0 = av; b0 = bv; end
            1:       begin st1 = s; op1 = o; a1 = av; b1 = bv; end
            default: begin st2 = s; op2 = o; a2 = av[7:0]; b2 = bv[7:0]; end
        endcase
    endtask

    function automatic logic g_done(input int sel);
        case (sel)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    function automatic logic g_busy(input int sel);
        case (sel)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic g_dz(input int sel);
        case (sel)
            0:       return dz0;
            1:       return dz1;
            default: return dz2;
        endcase
    endfunction

    function automatic logic [31:0] g_hi(input int sel);
        case (sel)
            0:       return hi0;
            1:       return hi1;
            default: return {24'h0, hi2};
        endcase
    endfunction

    function automatic logic [31:0] g_lo(input int sel);
        case (sel)
            0:       return lo0;
            1:       return lo1;
            default: return {24'h0, lo2};
        endcase
    endfunction

    // Start one operation at edge k (start raised just after edge k, sampled
    // at k+1), then wait for done and score it. poke>0 pulses a competing
    // start during busy cycle 'poke', which must be ignored.
    task automatic run_op(input int sel, input string tag, input logic [1:0] o,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edz, input int elat, input int poke);
        exp_t e;
        int   cyc;
        bit   stray;
        e.hi = ehi; e.lo = elo; e.dz = edz; e.lat = elat;
        sbq.push_back(e);
        @(posedge clock); #1;
        drive(sel, 1'b1, o, av, bv);
        @(posedge clock); #1;
        drive(sel, 1'b0, 2'b00, 32'h0, 32'h0);
        cyc = 1;
        if (elat > 1) chk({tag, " busy_after_accept"}, 64'(g_busy(sel)), 64'd1);
        while (!g_done(sel) && cyc < 200) begin
            if (cyc == poke) drive(sel, 1'b1, 2'b01, 32'h1234_5678, 32'h0000_0009);
            @(posedge clock); #1;
            if (cyc == poke) drive(sel, 1'b0, 2'b00, 32'h0, 32'h0);
            cyc++;
        end
        chk({tag, " done_seen"}, 64'(g_done(sel)), 64'd1);
        if (g_done(sel)) begin
            if (sbq.size() == 0) begin
                chk({tag, " scoreboard_nonempty"}, 64'(sbq.size()), 64'd1);
            end else begin
                e = sbq.pop_front();
                chk({tag, " latency"}, 64'(cyc), 64'(e.lat));
                chk({tag, " hi"}, 64'(g_hi(sel)), 64'(e.hi));
                chk({tag, " lo"}, 64'(g_lo(sel)), 64'(e.lo));
                chk({tag, " div0"}, 64'(g_dz(sel)), 64'(e.dz));
                chk({tag, " busy_at_done"}, 64'(g_busy(sel)), 64'd0);
            end
        end
        @(posedge clock); #1;
        chk({tag, " done_one_cycle"}, 64'(g_done(sel)), 64'd0);
        chk({tag, " div0_one_cycle"}, 64'(g_dz(sel)), 64'd0);
        chk({tag, " hi_hold"}, 64'(g_hi(sel)), 64'(ehi));
        chk({tag, " lo_hold"}, 64'(g_lo(sel)), 64'(elo));
        if (poke > 0) begin
            stray = 1'b0;
            repeat (40) begin
                @(posedge clock); #1;
                if (g_done(sel) || g_busy(sel)) stray = 1'b1;
            end
            chk({tag, " ignored_start_no_activity"}, 64'(stray), 64'd0);
        end
    endtask

    initial begin
        logic [31:0]        ra, rb;
        logic [63:0]        p;
        logic signed [31:0] sa, sb, sq, sr;
        logic signed [63:0] sp;
        bit                 stray;

        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        drive(0, 1'b0, 2'b00, 32'h0, 32'h0);
        drive(1, 1'b0, 2'b00, 32'h0, 32'h0);
        drive(2, 1'b0, 2'b00, 32'h0, 32'h0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        chk("reset busy", 64'(busy0), 64'd0);
        chk("reset done", 64'(done0), 64'd0);
        chk("reset hi", 64'(hi0), 64'd0);
        chk("reset lo", 64'(lo0), 64'd0);
        chk("reset div0", 64'(dz0), 64'd0);
        chk("reset u8 lo", 64'(lo2), 64'd0);

        run_op(0, "mult_m3x7",   2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34, 0);
        run_op(0, "multu_max",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34, 0);
        run_op(1, "nosign_op00", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34, 0);
        run_op(0, "div_m7d2",    2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, 0);
        run_op(0, "divu_m7d2",   2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0, 34, 0);
        run_op(0, "divu_by0",    2'b11, 32'h0000_0100, 32'h0000_0000, 32'h0000_0001, 32'h7FFF_FFFC, 1'b1, 1, 0);
        run_op(0, "div_min_m1",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 34, 0);
        run_op(0, "mult_poke",   2'b00, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 32'h0000_001E, 1'b0, 34, 5);

        // Abort an operation with reset at busy cycle 10.
        @(posedge clock); #1;
        drive(0, 1'b1, 2'b00, 32'h0000_0005, 32'h0000_0006);
        @(posedge clock); #1;
        drive(0, 1'b0, 2'b00, 32'h0, 32'h0);
        repeat (9) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("abort busy", 64'(busy0), 64'd0);
        chk("abort done", 64'(done0), 64'd0);
        chk("abort hi", 64'(hi0), 64'd0);
        chk("abort lo", 64'(lo0), 64'd0);
        chk("abort div0", 64'(dz0), 64'd0);
        stray = 1'b0;
        repeat (40) begin
            @(posedge clock); #1;
            if (done0 || busy0) stray = 1'b1;
        end
        chk("abort no_done", 64'(stray), 64'd0);

        run_op(0, "div_after_reset", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34, 0);
        run_op(0, "mult_backtoback", 2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h0000_0000, 32'h0000_0004, 1'b0, 34, 0);

        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = $urandom;
            p  = 64'(ra) * 64'(rb);
            run_op(0, "rnd_multu", 2'b01, ra, rb, p[63:32], p[31:0], 1'b0, 34, 0);
        end
        for (int i = 0; i < 3; i++) begin
            sa = $signed($urandom);
            sb = $signed($urandom);
            sp = {{32{sa[31]}}, sa} * {{32{sb[31]}}, sb};
            run_op(0, "rnd_mult", 2'b00, sa, sb, sp[63:32], sp[31:0], 1'b0, 34, 0);
        end
        for (int i = 0; i < 3; i++) begin
            sa = $signed($urandom);
            sb = $signed($urandom_range(1, 5000));
            if (i == 1) sb = -sb;
            if (i == 2) sa = -(sa >>> 4);
            sq = sa / sb;
            sr = sa % sb;
            run_op(0, "rnd_div", 2'b10, sa, sb, sr, sq, 1'b0, 34, 0);
        end
        ra = $urandom;
        rb = $urandom_range(1, 1000);
        run_op(0, "rnd_divu", 2'b11, ra, rb, ra % rb, ra / rb, 1'b0, 34, 0);

        run_op(2, "u8_mult_7xm2", 2'b00, 32'h07, 32'hFE, 32'hFF, 32'hF2, 1'b0, 10, 0);
        run_op(2, "u8_div_m7d2",  2'b10, 32'hF9, 32'h02, 32'hFF, 32'hFD, 1'b0, 10, 0);
        run_op(2, "u8_divu",      2'b11, 32'hFE, 32'h07, 32'h02, 32'h24, 1'b0, 10, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
